// File: rtl/alu_op_driver.sv
// Registered, flow-controlled operand driver and result capture for the 16-bit ALU.
// Optional sticky-flag accumulation is enabled by defining ALU_DRV_STICKY_FLAGS_EN.
module alu_op_driver #(
  parameter int WIDTH    = 16,
  parameter int FLAG_W   = 5,
  parameter int ALU_WAIT = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [WIDTH-1:0]  req_a,
  input  logic [WIDTH-1:0]  req_b,
  output logic [WIDTH-1:0]  alu_a,
  output logic [WIDTH-1:0]  alu_b,
  output logic [1:0]        alu_control,
  input  logic [WIDTH-1:0]  alu_res,
  input  logic [FLAG_W-1:0] alu_flags,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WIDTH-1:0]  rsp_res,
  output logic [FLAG_W-1:0] rsp_flags,
  output logic [15:0]       op_count,
  output logic [FLAG_W-1:0] sticky_flags,
  input  logic              flags_clr
);

  localparam logic [2:0] WAIT_INIT = 3'(ALU_WAIT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t            r_state;
  logic [2:0]        r_cnt;
  logic [WIDTH-1:0]  r_alu_a;
  logic [WIDTH-1:0]  r_alu_b;
  logic [1:0]        r_alu_ctl;
  logic [WIDTH-1:0]  r_rsp_res;
  logic [FLAG_W-1:0] r_rsp_flags;
  logic [15:0]       r_op_count;
  logic              r_req_ready;
  logic              r_rsp_valid;
  logic              w_capture;

  assign w_capture = (r_state == S_WAIT) && (r_cnt == 3'd0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_ctl   <= '0;
      r_rsp_res   <= '0;
      r_rsp_flags <= '0;
      r_op_count  <= '0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_alu_a     <= req_a;
            r_alu_b     <= req_b;
            r_alu_ctl   <= req_op;
            r_cnt       <= WAIT_INIT;
            r_req_ready <= 1'b0;
            r_state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_cnt == 3'd0) begin
            r_rsp_res   <= alu_res;
            r_rsp_flags <= alu_flags;
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESP;
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_op_count  <= r_op_count + 16'd1;
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_rsp_valid <= 1'b0;
          r_req_ready <= 1'b1;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  // Ready is suppressed during reset even though the state register says IDLE.
  assign req_ready   = r_req_ready & rst_n;
  assign rsp_valid   = r_rsp_valid;
  assign alu_a       = r_alu_a;
  assign alu_b       = r_alu_b;
  assign alu_control = r_alu_ctl;
  assign rsp_res     = r_rsp_res;
  assign rsp_flags   = r_rsp_flags;
  assign op_count    = r_op_count;

`ifdef ALU_DRV_STICKY_FLAGS_EN
  logic [FLAG_W-1:0] r_sticky;

  // Clear takes priority, then the captured flags are ORed in.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sticky <= '0;
    end else if (flags_clr) begin
      r_sticky <= w_capture ? alu_flags : '0;
    end else if (w_capture) begin
      r_sticky <= r_sticky | alu_flags;
    end
  end

  assign sticky_flags = r_sticky;
`else
  logic w_unused_clr;

  assign w_unused_clr = flags_clr ^ w_capture;
  assign sticky_flags = '0;
`endif

endmodule

// File: tb/tb_alu_op_driver.sv
// Directed self-checking bench for alu_op_driver.
// Uses one ALU_WAIT=0 instance and one ALU_WAIT=3 instance.
module tb_alu_op_driver;

`ifdef ALU_DRV_STICKY_FLAGS_EN
  localparam bit STK = 1'b1;
`else
  localparam bit STK = 1'b0;
`endif

  int checks   = 0;
  int failures = 0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_valid3;
  logic [1:0]  req_op;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic        rsp_ready;
  logic        flags_clr;
  logic [4:0]  m_flags;
  logic [15:0] m_res3;

  logic        req_ready0, rsp_valid0;
  logic [15:0] alu_a0, alu_b0, alu_res0, rsp_res0, op_count0;
  logic [1:0]  alu_ctl0;
  logic [4:0]  rsp_flags0, sticky0;

  logic        req_ready3, rsp_valid3;
  logic [15:0] alu_a3, alu_b3, rsp_res3, op_count3;
  logic [1:0]  alu_ctl3;
  logic [4:0]  rsp_flags3, sticky3;

  always #5 clk = ~clk;

  // ALU model: plain add for every code.
  assign alu_res0 = alu_a0 + alu_b0;

  alu_op_driver #(.WIDTH(16), .FLAG_W(5), .ALU_WAIT(0)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready0),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .alu_a(alu_a0), .alu_b(alu_b0), .alu_control(alu_ctl0),
    .alu_res(alu_res0), .alu_flags(m_flags),
    .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready),
    .rsp_res(rsp_res0), .rsp_flags(rsp_flags0),
    .op_count(op_count0), .sticky_flags(sticky0),
    .flags_clr(flags_clr)
  );

  alu_op_driver #(.WIDTH(16), .FLAG_W(5), .ALU_WAIT(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid3), .req_ready(req_ready3),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .alu_a(alu_a3), .alu_b(alu_b3), .alu_control(alu_ctl3),
    .alu_res(m_res3), .alu_flags(5'b00000),
    .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready),
    .rsp_res(rsp_res3), .rsp_flags(rsp_flags3),
    .op_count(op_count3), .sticky_flags(sticky3),
    .flags_clr(1'b0)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present a request on the WAIT=0 instance; returns at the negedge after accept.
  task automatic send(input logic [15:0] a, input logic [15:0] b,
                      input logic [1:0] op);
    req_a     = a;
    req_b     = b;
    req_op    = op;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  initial begin
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_valid3 = 1'b0;
    req_op     = 2'b00;
    req_a      = '0;
    req_b      = '0;
    rsp_ready  = 1'b1;
    flags_clr  = 1'b0;
    m_flags    = '0;
    m_res3     = 16'h1111;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready0), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid0), 32'd0);
    chk("rst_alu_a", 32'(alu_a0), 32'h0);
    chk("rst_op_count", 32'(op_count0), 32'h0);
    chk("rst_sticky", 32'(sticky0), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_req_ready", 32'(req_ready0), 32'd1);

    // 7 + 7
    send(16'h0007, 16'h0007, 2'b00);
    chk("t1_alu_a", 32'(alu_a0), 32'h0007);
    chk("t1_alu_b", 32'(alu_b0), 32'h0007);
    chk("t1_alu_ctl", 32'(alu_ctl0), 32'h0);
    chk("t1_req_ready", 32'(req_ready0), 32'd0);
    chk("t1_rsp_valid_early", 32'(rsp_valid0), 32'd0);
    @(negedge clk);
    chk("t1_rsp_valid", 32'(rsp_valid0), 32'd1);
    chk("t1_rsp_res", 32'(rsp_res0), 32'h000E);
    @(negedge clk);
    chk("t1_rsp_done", 32'(rsp_valid0), 32'd0);
    chk("t1_op_count", 32'(op_count0), 32'd1);
    chk("t1_req_ready_back", 32'(req_ready0), 32'd1);

    // FFFF + 1 wraps, flags captured
    m_flags = 5'b00110;
    send(16'hFFFF, 16'h0001, 2'b00);
    @(negedge clk);
    m_flags = 5'b00000;
    chk("t2_rsp_res", 32'(rsp_res0), 32'h0000);
    chk("t2_rsp_flags", 32'(rsp_flags0), 32'h06);
    chk("t2_sticky", 32'(sticky0), STK ? 32'h06 : 32'h0);
    @(negedge clk);
    chk("t2_op_count", 32'(op_count0), 32'd2);

    // Back-pressure with a pending request
    rsp_ready = 1'b0;
    m_flags   = 5'b00001;
    send(16'h0001, 16'h0002, 2'b00);
    @(negedge clk);
    chk("st_rsp_valid", 32'(rsp_valid0), 32'd1);
    m_flags   = 5'b11111;
    req_a     = 16'h0100;
    req_b     = 16'h0001;
    req_op    = 2'b01;
    req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("st_rsp_res", 32'(rsp_res0), 32'h0003);
      chk("st_rsp_flags", 32'(rsp_flags0), 32'h01);
      chk("st_req_ready", 32'(req_ready0), 32'd0);
      chk("st_alu_a_hold", 32'(alu_a0), 32'h0001);
    end
    m_flags   = 5'b00000;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("st_hs_valid", 32'(rsp_valid0), 32'd0);
    chk("st_hs_count", 32'(op_count0), 32'd3);
    chk("st_hs_alu_a", 32'(alu_a0), 32'h0001);
    @(negedge clk);
    req_valid = 1'b0;
    chk("st_new_alu_a", 32'(alu_a0), 32'h0100);
    chk("st_new_ctl", 32'(alu_ctl0), 32'h1);
    @(negedge clk);
    chk("st_new_res", 32'(rsp_res0), 32'h0101);
    chk("st_sticky", 32'(sticky0), STK ? 32'h07 : 32'h0);
    @(negedge clk);
    chk("st_new_count", 32'(op_count0), 32'd4);

    // Op code 11 passes through unfiltered
    send(16'h0005, 16'h0003, 2'b11);
    chk("op3_ctl", 32'(alu_ctl0), 32'h3);
    @(negedge clk);
    chk("op3_res", 32'(rsp_res0), 32'h0008);
    @(negedge clk);
    chk("op3_count", 32'(op_count0), 32'd5);

    // Sticky clear while idle, accumulate, then clear on the capture edge
    flags_clr = 1'b1;
    @(negedge clk);
    flags_clr = 1'b0;
    chk("clr_idle", 32'(sticky0), 32'h0);
    m_flags = 5'b00011;
    send(16'h0010, 16'h0020, 2'b00);
    @(negedge clk);
    chk("acc_sticky", 32'(sticky0), STK ? 32'h03 : 32'h0);
    @(negedge clk);
    m_flags = 5'b00000;
    send(16'h0001, 16'h0001, 2'b00);
    m_flags   = 5'b10000;
    flags_clr = 1'b1;
    @(negedge clk);
    flags_clr = 1'b0;
    m_flags   = 5'b00000;
    chk("clr_cap_sticky", 32'(sticky0), STK ? 32'h10 : 32'h0);
    chk("clr_cap_flags", 32'(rsp_flags0), 32'h10);
    @(negedge clk);

    // ALU_WAIT=3: capture at accept+4
    req_a      = 16'h00AA;
    req_b      = 16'h0055;
    req_op     = 2'b10;
    req_valid3 = 1'b1;
    @(negedge clk);
    req_valid3 = 1'b0;
    chk("w3_alu_a", 32'(alu_a3), 32'h00AA);
    chk("w3_ctl", 32'(alu_ctl3), 32'h2);
    @(negedge clk);
    chk("w3_valid_a1", 32'(rsp_valid3), 32'd0);
    m_res3 = 16'h2222;
    @(negedge clk);
    chk("w3_valid_a2", 32'(rsp_valid3), 32'd0);
    @(negedge clk);
    chk("w3_valid_a3", 32'(rsp_valid3), 32'd0);
    @(negedge clk);
    chk("w3_valid_a4", 32'(rsp_valid3), 32'd1);
    chk("w3_res", 32'(rsp_res3), 32'h2222);
    @(negedge clk);
    chk("w3_count", 32'(op_count3), 32'd1);
    chk("w3_ready", 32'(req_ready3), 32'd1);

    // Reset one cycle after accept drops the transaction
    send(16'h1234, 16'h0001, 2'b00);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mr_rsp_valid", 32'(rsp_valid0), 32'd0);
    chk("mr_alu_a", 32'(alu_a0), 32'h0);
    chk("mr_alu_b", 32'(alu_b0), 32'h0);
    chk("mr_rsp_res", 32'(rsp_res0), 32'h0);
    chk("mr_op_count", 32'(op_count0), 32'h0);
    chk("mr_req_ready", 32'(req_ready0), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mr_rel_ready", 32'(req_ready0), 32'd1);
    chk("mr_rel_valid", 32'(rsp_valid0), 32'd0);
    @(negedge clk);
    chk("mr_no_resp", 32'(rsp_valid0), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_op_driver.md
# alu_op_driver

Initiator-side driver for the 16-bit ALU. It accepts one operation request at a time over a valid/ready handshake and drives the ALU operand and control inputs from registers. After a configurable settle time it captures the ALU result and flags and returns them over a second valid/ready handshake. It sits between the datapath control logic and the ALU and replaces direct combinational wiring of operands with a registered, flow-controlled transaction.

## Interface
Parameters:
- `WIDTH`, 16, operand/result width
- `FLAG_W`, 5, ALU flag vector width
- `ALU_WAIT`, 0, extra settle cycles before capture; legal range 0..7

Ports:
- `clk`  in  1  clock, all logic on rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `req_valid`  in  1  request present
- `req_ready`  out  1  block can accept a request
- `req_op`  in  2  ALU control code, passed through unmodified
- `req_a`, `req_b`  in  WIDTH  operands
- `alu_a`, `alu_b`  out  WIDTH  registered operands to ALU
- `alu_control`  out  2  registered op code to ALU
- `alu_res`  in  WIDTH  ALU result (combinational from ALU)
- `alu_flags`  in  FLAG_W  ALU flags
- `rsp_valid`  out  1  response present
- `rsp_ready`  in  1  consumer accepts response
- `rsp_res`  out  WIDTH  captured result
- `rsp_flags`  out  FLAG_W  captured flags
- `op_count`  out  16  completed-transaction counter
- `sticky_flags`  out  FLAG_W  accumulated flags (see Configuration)
- `flags_clr`  in  1  clear `sticky_flags`

## Operation
- FSM states: `IDLE`, `WAIT`, `RESP`.
- `IDLE`:
  - `req_ready`=1.
  - On `req_valid && req_ready`, register `req_a`, `req_b` and `req_op` into `alu_a`, `alu_b` and `alu_control`.
  - Load wait counter with `ALU_WAIT`, then go to `WAIT`.
- `WAIT`:
  - If counter==0, capture `alu_res`→`rsp_res` and `alu_flags`→`rsp_flags`, then go to `RESP`.
  - Otherwise decrement the counter.
- `RESP`:
  - `rsp_valid`=1.
  - `rsp_res` and `rsp_flags` are held stable until `rsp_valid && rsp_ready`.
  - On that handshake, increment `op_count` and return to `IDLE`.
- `alu_*` outputs hold their last value after a transaction. They change only on request acceptance.
- `req_op` value 2'b11 is not filtered. It is driven to the ALU and its result is captured like any other code.
- `op_count` wraps 0xFFFF→0x0000 silently.
- `req_ready` is 0 in `WAIT` and `RESP`. `req_valid` asserted there is ignored and must be held by the requester.
- Reset (`rst_n`=0 at an edge):
  - State goes to `IDLE`.
  - Cleared to 0: `alu_a`, `alu_b`, `alu_control`, `rsp_res`, `rsp_flags`, `op_count`, `sticky_flags`.
  - `rsp_valid`=0.
  - `req_ready` is forced to 0 while `rst_n` is low.
- Reset mid-transaction drops the transaction with no response, and `op_count` is not incremented.

## Timing
- Request accepted at edge N → `alu_*` valid after edge N.
- Capture at edge N+1+`ALU_WAIT` → `rsp_valid` high after that edge.
- With `rsp_ready` held at 1:
  - Response handshake occurs at edge N+2+`ALU_WAIT`.
  - `req_ready` is high again after that edge.
  - Next accept is possible at edge N+3+`ALU_WAIT`.
- Throughput is one operation per 3+`ALU_WAIT` cycles.
- `req_ready` and `rsp_valid` are decoded from state only. There is no combinational path from `req_valid` or `rsp_ready`.
- Back-pressure on `rsp_ready` stalls indefinitely with no data loss.

## Configuration
- Macro: `ALU_DRV_STICKY_FLAGS_EN`.
- Defined:
  - On every capture edge, `sticky_flags` ← `sticky_flags | alu_flags`.
  - `flags_clr`=1 at an edge clears `sticky_flags`.
  - If `flags_clr` and a capture occur on the same edge, result = `alu_flags` (clear first, then OR).
- Undefined:
  - `sticky_flags` is tied to 0 and `flags_clr` is ignored.
  - No accumulation register is synthesized.

## Test plan
- Reset, then A=0x0007, B=0x0007, op=2'b00 with ALU model = add, `ALU_WAIT`=0, `rsp_ready`=1 → `alu_*` = 0x0007/0x0007/00 one edge after accept. Then `rsp_valid` after accept+1, `rsp_res`=0x000E, `op_count`=1.
- A=0xFFFF, B=0x0001, op=00, model flags=5'b00110 → `rsp_res`=0x0000, `rsp_flags`=5'b00110. With macro defined, `sticky_flags`=5'b00110.
- `rsp_ready`=0 for 5 cycles after `rsp_valid` rises, with `req_valid`=1 and new operands during the stall → `rsp_res` stable, `req_ready`=0 throughout, and the new request is accepted only one edge after the handshake.
- `ALU_WAIT`=3 with the ALU model changing `alu_res` from 0x1111 to 0x2222 two cycles after accept → captured value = model output at edge accept+4 (0x2222).
- Preload `op_count`=0xFFFF via 65535 transactions, then one more transaction → `op_count`=0x0000. Separately, `flags_clr` asserted on the capture edge with flags 5'b10000 and prior sticky 5'b00011 → `sticky_flags`=5'b10000.
- `rst_n`=0 one cycle after accept → at the next edge `rsp_valid`=0, all outputs 0, `op_count` unchanged at 0. After reset release `req_ready`=1.
